// File: rtl/hsv_frame_receiver.sv
// HSV serial pixel receiver: synchronises the Pi bit clock/data and thresholds each pixel into a LENGTH x WIDTH hand mask.
// Optional trailing frame checksum is enabled by the FRAME_CHECKSUM_EN macro.
module hsv_frame_receiver #(
  parameter int LENGTH         = 28,
  parameter int WIDTH          = 28,
  parameter int CH_BITS        = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                      fpga_clk,
  input  logic                      rst_n,
  input  logic                      pi_clk,
  input  logic                      data_in,
  input  logic [CH_BITS-1:0]        min_hue,
  input  logic [CH_BITS-1:0]        max_hue,
  input  logic [CH_BITS-1:0]        min_sat,
  input  logic [CH_BITS-1:0]        min_val,
  input  logic                      frame_ack,
  output logic [LENGTH*WIDTH-1:0]   mask,
  output logic                      frame_valid,
  output logic                      overrun,
  output logic                      timeout,
`ifdef FRAME_CHECKSUM_EN
  output logic                      csum_err,
`endif
  output logic                      busy
);

  localparam int PIX_BITS = 3 * CH_BITS;
  localparam int CNT_MAX  = (PIX_BITS > 8) ? PIX_BITS : 8;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int ROW_W    = $clog2((LENGTH > 1) ? LENGTH : 2);
  localparam int COL_W    = $clog2((WIDTH > 1) ? WIDTH : 2);
  localparam int IDX_W    = $clog2((LENGTH * WIDTH > 1) ? LENGTH * WIDTH : 2);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
`ifdef FRAME_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]    r_pi_sync, r_dat_sync;
  logic                      r_pi_prev;
  logic [PIX_BITS-2:0]       r_shift;
  logic [CNT_W-1:0]          r_bit_cnt;
  logic [ROW_W-1:0]          r_row;
  logic [COL_W-1:0]          r_col;
  logic [TO_W-1:0]           r_to_cnt;
  logic [LENGTH*WIDTH-1:0]   r_mask;
  logic                      r_overrun, r_timeout;
`ifdef FRAME_CHECKSUM_EN
  logic [6:0]                r_csum_sh;
  logic [7:0]                r_sum;
  logic                      r_csum_err;
`endif

  logic                      w_pi, w_dat, w_strobe, w_busy, w_to_hit;
  logic                      w_last_bit, w_last_pix, w_hand;
  logic [PIX_BITS-1:0]       w_pix;
  logic [CH_BITS-1:0]        w_h, w_s, w_v;
  logic [IDX_W-1:0]          w_idx;

  assign w_pi     = r_pi_sync[SYNC_STAGES-1];
  assign w_dat    = r_dat_sync[SYNC_STAGES-1];
  assign w_strobe = w_pi & ~r_pi_prev;
`ifdef FRAME_CHECKSUM_EN
  assign w_busy   = (r_state == S_RECV) || (r_state == S_CSUM);
`else
  assign w_busy   = (r_state == S_RECV);
`endif
  assign w_to_hit = w_busy && !w_strobe && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // The final bit is classified straight off the synchroniser so the write lands on the strobe edge.
  assign w_pix      = {w_dat, r_shift};
  assign w_h        = w_pix[CH_BITS-1:0];
  assign w_s        = w_pix[2*CH_BITS-1:CH_BITS];
  assign w_v        = w_pix[3*CH_BITS-1:2*CH_BITS];
  assign w_hand     = (w_h >= min_hue) && (w_h <= max_hue) && (w_s >= min_sat) && (w_v >= min_val);
  assign w_last_bit = (r_bit_cnt == CNT_W'(PIX_BITS - 1));
  assign w_last_pix = (r_row == ROW_W'(LENGTH - 1)) && (r_col == COL_W'(WIDTH - 1));
  assign w_idx      = IDX_W'(32'(r_row) * WIDTH + 32'(r_col));

  assign mask        = r_mask;
  assign frame_valid = (r_state == S_DONE);
  assign overrun     = r_overrun;
  assign timeout     = r_timeout;
  assign busy        = w_busy;
`ifdef FRAME_CHECKSUM_EN
  assign csum_err    = r_csum_err;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_strobe) w_state_nxt = S_RECV;
      S_RECV: begin
        if (w_strobe && w_last_bit && w_last_pix) begin
`ifdef FRAME_CHECKSUM_EN
          w_state_nxt = S_CSUM;
`else
          w_state_nxt = S_DONE;
`endif
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef FRAME_CHECKSUM_EN
      S_CSUM: begin
        if (w_strobe && r_bit_cnt == CNT_W'(7)) w_state_nxt = S_DONE;
        else if (w_to_hit)                      w_state_nxt = S_IDLE;
      end
`endif
      S_DONE: if (frame_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pi_sync  <= '0;
      r_dat_sync <= '0;
      r_pi_prev  <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_to_cnt   <= '0;
      r_mask     <= '0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_csum_sh  <= '0;
      r_sum      <= '0;
      r_csum_err <= 1'b0;
`endif
    end else begin
      r_pi_sync  <= {r_pi_sync[SYNC_STAGES-2:0], pi_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], data_in};
      r_pi_prev  <= w_pi;
      r_timeout  <= w_to_hit;
      r_to_cnt   <= (w_busy && !w_strobe && !w_to_hit) ? r_to_cnt + 1'b1 : '0;

      if (w_to_hit) begin
        // Stale mask bits are left in place; the next frame overwrites them.
        r_bit_cnt <= '0;
        r_row     <= '0;
        r_col     <= '0;
`ifdef FRAME_CHECKSUM_EN
        r_sum     <= '0;
`endif
      end else begin
        case (r_state)
          S_IDLE, S_RECV: begin
            if (w_strobe) begin
              if (w_last_bit) begin
                r_mask[w_idx] <= w_hand;
                r_bit_cnt     <= '0;
`ifdef FRAME_CHECKSUM_EN
                r_sum         <= r_sum + 8'(w_h) + 8'(w_s) + 8'(w_v);
`endif
                if (w_last_pix) begin
                  r_row <= '0;
                  r_col <= '0;
                end else if (r_col == COL_W'(WIDTH - 1)) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
                end else begin
                  r_col <= r_col + 1'b1;
                end
              end else begin
                r_shift[r_bit_cnt] <= w_dat;
                r_bit_cnt          <= r_bit_cnt + 1'b1;
              end
            end
          end
`ifdef FRAME_CHECKSUM_EN
          S_CSUM: begin
            if (w_strobe) begin
              if (r_bit_cnt == CNT_W'(7)) begin
                r_csum_err <= ({w_dat, r_csum_sh} != r_sum);
                r_bit_cnt  <= '0;
              end else begin
                r_csum_sh[r_bit_cnt[2:0]] <= w_dat;
                r_bit_cnt                 <= r_bit_cnt + 1'b1;
              end
            end
          end
`endif
          S_DONE: begin
            // Ack wins over a coincident strobe: the bit is dropped without flagging overrun.
            if (frame_ack) begin
              r_overrun <= 1'b0;
              r_bit_cnt <= '0;
              r_row     <= '0;
              r_col     <= '0;
`ifdef FRAME_CHECKSUM_EN
              r_sum      <= '0;
              r_csum_err <= 1'b0;
`endif
            end else if (w_strobe) begin
              r_overrun <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hsv_frame_receiver.sv
// Scoreboard bench for hsv_frame_receiver on a 4x4 mask with a short idle timeout.
module tb_hsv_frame_receiver;
  localparam int L = 4;
  localparam int W = 4;
  localparam int NPIX = L * W;

  logic fpga_clk = 1'b0, rst_n = 1'b0, pi_clk = 1'b0, data_in = 1'b0, frame_ack = 1'b0;
  logic [7:0] min_hue = 8'd10, max_hue = 8'd20, min_sat = 8'd50, min_val = 8'd50;
  logic [NPIX-1:0] mask;
  logic frame_valid, overrun, timeout, busy;
`ifdef FRAME_CHECKSUM_EN
  logic csum_err;
`endif

  int total = 0, bad = 0;
  logic [NPIX-1:0] exp_q[$];
  logic [NPIX-1:0] last_mask;
  logic [23:0] pix[NPIX];
  logic csum_corrupt = 1'b0;

  always #5 fpga_clk = ~fpga_clk;

  hsv_frame_receiver #(.LENGTH(L), .WIDTH(W), .CH_BITS(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
    .fpga_clk(fpga_clk), .rst_n(rst_n), .pi_clk(pi_clk), .data_in(data_in),
    .min_hue(min_hue), .max_hue(max_hue), .min_sat(min_sat), .min_val(min_val),
    .frame_ack(frame_ack), .mask(mask), .frame_valid(frame_valid), .overrun(overrun),
    .timeout(timeout),
`ifdef FRAME_CHECKSUM_EN
    .csum_err(csum_err),
`endif
    .busy(busy)
  );

  function automatic logic [23:0] mk(input int h, input int s, input int v);
    return {8'(v), 8'(s), 8'(h)};
  endfunction

  function automatic logic model_hand(input logic [23:0] p);
    return (p[7:0] >= min_hue) && (p[7:0] <= max_hue) && (p[15:8] >= min_sat) && (p[23:16] >= min_val);
  endfunction

  task automatic send_bit(input logic b);
    data_in = b;
    repeat (2) @(negedge fpga_clk);
    pi_clk = 1'b1;
    repeat (4) @(negedge fpga_clk);
    pi_clk = 1'b0;
    repeat (2) @(negedge fpga_clk);
  endtask

  task automatic send_pixels(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      for (int k = 0; k < 24; k++) send_bit(pix[i][k]);
  endtask

  task automatic push_expected();
    logic [NPIX-1:0] e;
    for (int i = 0; i < NPIX; i++) e[i] = model_hand(pix[i]);
    exp_q.push_back(e);
  endtask

  task automatic send_csum();
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < NPIX; i++) sum = sum + pix[i][7:0] + pix[i][15:8] + pix[i][23:16];
    if (csum_corrupt) sum[3] = ~sum[3];
    for (int k = 0; k < 8; k++) send_bit(sum[k]);
`endif
  endtask

  task automatic send_frame();
    push_expected();
    send_pixels(0, NPIX - 1);
    send_csum();
  endtask

  task automatic check_frame(input string name);
    logic [NPIX-1:0] e;
    int n;
    n = 0;
    while (!frame_valid && n < 200) begin
      @(negedge fpga_clk);
      n++;
    end
    total++;
    if (!frame_valid) begin
      bad++;
      $display("FAIL %s_valid: frame_valid=%0b required 1 within 200 cycles", name, frame_valid);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    total++;
    if (mask !== e) begin
      bad++;
      $display("FAIL %s_mask: got %h required %h", name, mask, e);
    end
    last_mask = e;
`ifdef FRAME_CHECKSUM_EN
    total++;
    if (csum_err !== csum_corrupt) begin
      bad++;
      $display("FAIL %s_csum: csum_err=%0b required %0b", name, csum_err, csum_corrupt);
    end
`endif
  endtask

  task automatic do_ack();
    @(negedge fpga_clk);
    frame_ack = 1'b1;
    @(negedge fpga_clk);
    frame_ack = 1'b0;
    @(negedge fpga_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge fpga_clk);
    total++;
    if ({mask, frame_valid, overrun, timeout, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b required all 0", mask, frame_valid, overrun, timeout, busy);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) send_bit(k[0]);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy_midstream: busy=%0b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({frame_valid, overrun, timeout, busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_async: got %b required 0000", {frame_valid, overrun, timeout, busy});
    end
    @(negedge fpga_clk);
    rst_n = 1'b1;
    send_bit(1'b1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_bit: busy=%0b required 1", busy);
    end
    rst_n = 1'b0;
    @(negedge fpga_clk);
    rst_n = 1'b1;
    @(negedge fpga_clk);
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < NPIX; i++) pix[i] = (i % 2 == 0) ? mk(15, 60, 60) : mk(30, 60, 60);
    send_frame();
    check_frame("full");
    total++;
    if (mask !== 16'h5555) begin
      bad++;
      $display("FAIL full_const: got %h required 5555", mask);
    end
    total++;
    if ({overrun, busy} !== 2'b00) begin
      bad++;
      $display("FAIL full_flags: overrun/busy=%b required 00", {overrun, busy});
    end
    do_ack();
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_ack: frame_valid=%0b required 0", frame_valid);
    end
  endtask

  task automatic test_boundary();
    pix[0] = mk(10, 60, 60); pix[1] = mk(20, 60, 60); pix[2] = mk(15, 50, 60); pix[3] = mk(15, 60, 50);
    pix[4] = mk(9, 60, 60);  pix[5] = mk(21, 60, 60); pix[6] = mk(15, 49, 60); pix[7] = mk(15, 60, 49);
    for (int i = 8; i < NPIX; i++) pix[i] = (i % 3 == 0) ? mk(12, 55, 70) : mk(255, 0, 0);
    send_frame();
    check_frame("boundary");
    total++;
    if (mask[7:0] !== 8'h0F) begin
      bad++;
      $display("FAIL boundary_low: got %h required 0f", mask[7:0]);
    end
    do_ack();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < NPIX; i++)
      pix[i] = mk($urandom_range(5, 25), $urandom_range(45, 55), $urandom_range(45, 55));
    send_frame();
    check_frame("ovr_first");
    for (int k = 0; k < 24; k++) send_bit(1'($urandom_range(0, 1)));
    total++;
    if ({mask, frame_valid, overrun} !== {last_mask, 2'b11}) begin
      bad++;
      $display("FAIL overrun_hold: mask=%h fv=%0b ovr=%0b required %h 1 1", mask, frame_valid, overrun, last_mask);
    end
    do_ack();
    total++;
    if ({frame_valid, overrun} !== 2'b00) begin
      bad++;
      $display("FAIL overrun_ack: fv/ovr=%b required 00", {frame_valid, overrun});
    end
    for (int i = 0; i < NPIX; i++) pix[i] = (i < 4) ? mk(15, 60, 60) : mk(0, 0, 0);
    send_frame();
    check_frame("ovr_next");
    do_ack();
  endtask

  task automatic test_ack_ignored();
    for (int i = 0; i < NPIX; i++) pix[i] = (i % 5 == 1) ? mk(18, 90, 90) : mk(3, 90, 90);
    push_expected();
    send_pixels(0, 4);
    do_ack();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL ack_ignored_busy: busy=%0b required 1", busy);
    end
    send_pixels(5, NPIX - 1);
    send_csum();
    check_frame("ack_ignored");
    do_ack();
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 30; k++) send_bit(1'($urandom_range(0, 1)));
    for (int c = 0; c < 300; c++) begin
      @(negedge fpga_clk);
      if (timeout === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL timeout_pulse: pulses=%0d required 1", pulses);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_busy: busy=%0b required 0", busy);
    end
    for (int i = 0; i < NPIX; i++) pix[i] = (i % 4 == 3) ? mk(11, 51, 51) : mk(40, 51, 51);
    send_frame();
    check_frame("timeout_resync");
    do_ack();
  endtask

  task automatic test_inverted_hue();
    min_hue = 8'd20;
    max_hue = 8'd10;
    for (int i = 0; i < NPIX; i++) pix[i] = mk(15, 200, 200);
    send_frame();
    check_frame("inverted");
    total++;
    if (mask !== '0) begin
      bad++;
      $display("FAIL inverted_zero: got %h required 0000", mask);
    end
    do_ack();
    min_hue = 8'd10;
    max_hue = 8'd20;
  endtask

  task automatic test_checksum();
    csum_corrupt = 1'b1;
    for (int i = 0; i < NPIX; i++) pix[i] = mk(i + 8, 100 + i, 60);
    send_frame();
    check_frame("csum_bad");
    do_ack();
    csum_corrupt = 1'b0;
    send_frame();
    check_frame("csum_good");
    do_ack();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_boundary();
    test_overrun();
    test_ack_ignored();
    test_timeout();
    test_inverted_hue();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
